// File: rtl/modn_seg7_display.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a time-multiplexed,
// common-anode 7-segment display with its own refresh divider, leading-zero
// blanking and an overflow indication (all digits show a dash).
module modn_seg7_display #(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WIDTH-1:0]  in_val,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int BCDN = (WIDTH + 2) / 3;
  localparam int SRW  = 4 * BCDN + WIDTH;
  localparam int NX   = (BCDN > DIGITS) ? BCDN : DIGITS;
  localparam int XW   = 4 * NX;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int RW   = $clog2(REFRESH_DIV);
  localparam int SW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [6:0]        SEG_ZERO  = 7'b1000000;
  localparam logic [6:0]        SEG_BLANK = 7'b1111111;
  localparam logic [6:0]        SEG_DASH  = 7'b0111111;
  localparam logic [DIGITS-1:0] AN_RST    = ~(DIGITS'(1));

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SRW-1:0] dabble_step(input logic [SRW-1:0] sr);
    logic [SRW-1:0] t;
    t = sr;
    for (int i = 0; i < BCDN; i++) begin
      if (t[WIDTH + 4*i +: 4] >= 4'd5) begin
        t[WIDTH + 4*i +: 4] = t[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    return {t[SRW-2:0], 1'b0};
  endfunction

  // Active-low gfedcba pattern for one decimal digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  logic [1:0]          state_q, state_d;
  logic [SRW-1:0]      sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [RW-1:0]       refresh_q, refresh_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [XW-1:0]       bcd_x;
  logic                ovf_new;

  // BCD result zero-extended so any DIGITS/BCDN combination can be sliced safely.
  assign bcd_x   = XW'(sr_q[SRW-1:WIDTH]);
  assign ovf_new = |(bcd_x >> (4 * DIGITS));

  // Converter FSM: accept in IDLE, WIDTH dabble steps, then commit the result in DONE.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sr_d    = {{(4*BCDN){1'b0}}, in_val};
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = dabble_step(sr_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        disp_d  = bcd_x[4*DIGITS-1:0];
        ovf_d   = ovf_new;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running refresh divider; advances the scanned digit on terminal count.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    scan_d    = scan_q;
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      scan_d    = (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end
  end

  // Segment/anode pattern for the currently scanned digit, with blanking and overflow.
  always_comb begin
    logic [DIGITS-1:0] blank_v;
    logic              higher_nz;
    logic [3:0]        nib;
    logic              blk;
    higher_nz = 1'b0;
    blank_v   = '0;
    nib       = '0;
    blk       = 1'b0;
    an_d      = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_nz  = higher_nz | (disp_q[4*i +: 4] != 4'd0);
      blank_v[i] = (i != 0) && !higher_nz;
    end
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = (scan_q != SW'(i));
      if (scan_q == SW'(i)) begin
        nib = disp_q[4*i +: 4];
        blk = blank_v[i];
      end
    end
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blk) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_decode(nib);
    end
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      refresh_q <= '0;
      scan_q    <= '0;
      an_q      <= AN_RST;
      seg_q     <= SEG_ZERO;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      refresh_q <= refresh_d;
      scan_q    <= scan_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = 1'b1;

endmodule

// File: tb/tb_modn_seg7_display.sv
// Directed bench for modn_seg7_display: a 4-bit and an 8-bit instance with a
// fast refresh divider, expected displays queued at acceptance and compared
// once each conversion has reached the scanned outputs.
module tb_modn_seg7_display;

  logic       clk;
  logic       rstn;

  logic [3:0] in_val4;
  logic       valid4, ready4, busy4, dp4;
  logic [6:0] seg4;
  logic [1:0] an4;

  logic [7:0] in_val8;
  logic       valid8, ready8, busy8, dp8;
  logic [6:0] seg8;
  logic [1:0] an8;

  int n_chk = 0;
  int n_err = 0;
  int exp4[$];
  int exp8[$];

  modn_seg7_display #(.WIDTH(4), .DIGITS(2), .REFRESH_DIV(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_val(in_val4), .in_valid(valid4),
    .in_ready(ready4), .busy(busy4), .seg(seg4), .dp(dp4), .an(an4)
  );

  modn_seg7_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) dut8 (
    .clk(clk), .rstn(rstn), .in_val(in_val8), .in_valid(valid8),
    .in_ready(ready8), .busy(busy8), .seg(seg8), .dp(dp8), .an(an8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] m_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Two-digit display model: dashes on overflow, upper digit blank when zero.
  task automatic model(input int v, output logic [6:0] e0, output logic [6:0] e1);
    if (v >= 100) begin
      e0 = 7'b0111111;
      e1 = 7'b0111111;
    end else begin
      e0 = m_seg(v % 10);
      e1 = (v / 10 == 0) ? 7'b1111111 : m_seg(v / 10);
    end
  endtask

  task automatic wait_idle(input bit sel);
    for (int i = 0; i < 40; i++) begin
      if ((sel ? ready8 : ready4) && !(sel ? busy8 : busy4)) break;
      tick();
    end
    chk("idle_wait", {31'd0, (sel ? ready8 : ready4)}, 32'd1);
  endtask

  task automatic convert(input bit sel, input int v);
    if (sel) begin
      in_val8 = 8'(v); valid8 = 1'b1; exp8.push_back(v);
    end else begin
      in_val4 = 4'(v); valid4 = 1'b1; exp4.push_back(v);
    end
    tick();
    valid4 = 1'b0;
    valid8 = 1'b0;
    wait_idle(sel);
    tick();
    tick();
  endtask

  task automatic check_disp(input bit sel);
    logic [6:0] s0, s1, e0, e1;
    logic [1:0] a;
    bit g0, g1;
    int v;
    g0 = 0; g1 = 0; s0 = '0; s1 = '0;
    for (int i = 0; i < 24 && !(g0 && g1); i++) begin
      tick();
      a = sel ? an8 : an4;
      if (a == 2'b10) begin s0 = sel ? seg8 : seg4; g0 = 1; end
      if (a == 2'b01) begin s1 = sel ? seg8 : seg4; g1 = 1; end
    end
    chk("scan_found", {30'd0, g1, g0}, 32'd3);
    v = sel ? exp8.pop_front() : exp4.pop_front();
    model(v, e0, e1);
    chk($sformatf("digit0_val%0d", v), {25'd0, s0}, {25'd0, e0});
    chk($sformatf("digit1_val%0d", v), {25'd0, s1}, {25'd0, e1});
  endtask

  initial begin
    rstn = 1'b0;
    in_val4 = '0; valid4 = 1'b0;
    in_val8 = '0; valid8 = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_an4", {30'd0, an4}, 32'h2);
    chk("rst_seg4", {25'd0, seg4}, 32'h40);
    chk("rst_dp4", {31'd0, dp4}, 32'd1);
    chk("rst_ready4", {31'd0, ready4}, 32'd1);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_an8", {30'd0, an8}, 32'h2);
    chk("rst_seg8", {25'd0, seg8}, 32'h40);
    rstn = 1'b1;

    // Scan: an holds each digit for 4 cycles, digit1 blank
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (((j - 1) / 4) % 2 == 0) begin
        chk($sformatf("scan_an_%0d", j), {30'd0, an4}, 32'h2);
        chk($sformatf("scan_seg_%0d", j), {25'd0, seg4}, 32'h40);
      end else begin
        chk($sformatf("scan_an_%0d", j), {30'd0, an4}, 32'h1);
        chk($sformatf("scan_seg_%0d", j), {25'd0, seg4}, 32'h7f);
      end
      chk($sformatf("scan_an8_%0d", j), {30'd0, an8}, {30'd0, an4});
    end

    // Convert 7 with handshake timing
    chk("pre_ready", {31'd0, ready4}, 32'd1);
    in_val4 = 4'd7; valid4 = 1'b1; exp4.push_back(7);
    tick();
    valid4 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("shift_busy_%0d", j), {31'd0, busy4}, 32'd1);
      chk($sformatf("shift_ready_%0d", j), {31'd0, ready4}, 32'd0);
      tick();
    end
    chk("done_ready", {31'd0, ready4}, 32'd0);
    tick();
    chk("idle_ready", {31'd0, ready4}, 32'd1);
    chk("idle_busy", {31'd0, busy4}, 32'd0);
    tick();
    check_disp(1'b0);

    // 9 then counter wrap to 0
    convert(1'b0, 9);
    check_disp(1'b0);
    convert(1'b0, 0);
    check_disp(1'b0);

    // 8-bit instance: two digits, then overflow
    convert(1'b1, 45);
    check_disp(1'b1);
    convert(1'b1, 255);
    check_disp(1'b1);

    // in_valid held during a conversion is ignored, not queued
    in_val4 = 4'd3; valid4 = 1'b1; exp4.push_back(3);
    tick();
    in_val4 = 4'd8;
    for (int i = 0; i < 20; i++) begin
      if (ready4) break;
      tick();
    end
    valid4 = 1'b0;
    chk("hold_ready", {31'd0, ready4}, 32'd1);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("no_queue_busy_%0d", j), {31'd0, busy4}, 32'd0);
    end
    check_disp(1'b0);
    convert(1'b0, 8);
    check_disp(1'b0);

    // Reset during a conversion aborts it
    convert(1'b0, 5);
    check_disp(1'b0);
    in_val4 = 4'd6; valid4 = 1'b1; exp4.push_back(6);
    tick();
    valid4 = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready4}, 32'd1);
    chk("abort_busy", {31'd0, busy4}, 32'd0);
    chk("abort_an", {30'd0, an4}, 32'h2);
    chk("abort_seg", {25'd0, seg4}, 32'h40);
    tick();
    tick();
    rstn = 1'b1;
    exp4.delete();
    exp4.push_back(0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("post_rst_busy_%0d", j), {31'd0, busy4}, 32'd0);
    end
    check_disp(1'b0);
    chk("dp_off", {31'd0, dp4}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
